// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run-control block: state encoding and command decode.
package run_ctrl_pkg;

  localparam int unsigned StateWidth = 3;

  typedef enum logic [StateWidth-1:0] {
    StInit   = 3'd0,
    StIdle   = 3'd1,
    StRun    = 3'd2,
    StStep   = 3'd3,
    StHalted = 3'd4
  } state_e;

  // Enumerator value is the command's priority rank: stop > start > step.
  typedef enum logic [1:0] {
    CmdNone  = 2'd0,
    CmdStep  = 2'd1,
    CmdStart = 2'd2,
    CmdStop  = 2'd3
  } cmd_e;

  function automatic cmd_e decode_cmd(input logic start, input logic step, input logic stop);
    if (stop) begin
      return CmdStop;
    end else if (start) begin
      return CmdStart;
    end else if (step) begin
      return CmdStep;
    end
    return CmdNone;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  output logic [Width-1:0] count,
  output logic             sat
);

  logic [Width-1:0] count_q, count_d;

  assign sat   = &count_q;
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !sat) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/run_control.sv
// Sequences CPU reset release, then gates CPU execution (run/step/stop) until halt or timeout.
module run_control
  import run_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned MAX_CYCLES = 1024,
  parameter int unsigned RESET_HOLD = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  step,
  input  logic                  stop,
  input  logic                  cpu_halt,
  output logic                  cpu_rst_n,
  output logic                  cpu_en,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [StateWidth-1:0] state,
  output logic                  done,
  output logic                  timeout
);

  localparam int unsigned HoldWidth = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HoldWidth-1:0] HoldLast   = HoldWidth'(RESET_HOLD - 1);
  localparam logic [CNT_WIDTH-1:0] BudgetLast = CNT_WIDTH'(MAX_CYCLES - 1);

  state_e               state_q, state_d;
  logic [HoldWidth-1:0] hold_q, hold_d;
  logic                 timeout_q, timeout_d;
  logic                 cpu_rst_n_q;
  logic                 cnt_clr;
  logic                 cnt_sat;
  logic                 budget_hit;
  cmd_e                 cmd;

  assign cmd = decode_cmd(start, step, stop);

  sat_counter #(
    .Width (CNT_WIDTH)
  ) u_cycle_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (cpu_en),
    .clr     (cnt_clr),
    .count   (cycle_count),
    .sat     (cnt_sat)
  );

  // Saturation can only coincide with the last budgeted cycle if the budget is illegal.
  assign budget_hit = (cycle_count == BudgetLast) || cnt_sat;

  always_comb begin
    state_d   = state_q;
    hold_d    = '0;
    timeout_d = timeout_q;
    cnt_clr   = 1'b0;
    unique case (state_q)
      StInit: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HoldLast) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        case (cmd)
          CmdStart: state_d = StRun;
          CmdStep:  state_d = StStep;
          default:  state_d = StIdle;
        endcase
      end
      StRun, StStep: begin
        if (cpu_halt) begin
          state_d = StHalted;
        end else if (budget_hit) begin
          state_d   = StHalted;
          timeout_d = 1'b1;
        end else if (state_q == StStep || stop) begin
          state_d = StIdle;
        end
      end
      StHalted: begin
        if (start) begin
          state_d   = StInit;
          timeout_d = 1'b0;
          cnt_clr   = 1'b1;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StInit;
      hold_q      <= '0;
      timeout_q   <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      timeout_q   <= timeout_d;
      // Released on the same edge that leaves INIT, reasserted on the edge that re-enters it.
      cpu_rst_n_q <= (state_d != StInit);
    end
  end

  assign cpu_en    = (state_q == StRun) || (state_q == StStep);
  assign cpu_rst_n = cpu_rst_n_q;
  assign state     = state_q;
  assign done      = (state_q == StHalted);
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_run_control.sv
// Self-checking bench for run_control: scoreboarded run/step transactions plus reset sequencing.
module tb_run_control;

  localparam int unsigned CntWidth  = 32;
  localparam int unsigned MaxCycles = 16;
  localparam int unsigned ResetHold = 4;

  localparam int SInit   = 0;
  localparam int SIdle   = 1;
  localparam int SHalted = 4;

  logic                clock;
  logic                reset_n;
  logic                start;
  logic                step;
  logic                stop;
  logic                cpu_halt;
  logic                cpu_rst_n;
  logic                cpu_en;
  logic [CntWidth-1:0] cycle_count;
  logic [2:0]          state;
  logic                done;
  logic                timeout;

  run_control #(
    .CNT_WIDTH  (CntWidth),
    .MAX_CYCLES (MaxCycles),
    .RESET_HOLD (ResetHold)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .step        (step),
    .stop        (stop),
    .cpu_halt    (cpu_halt),
    .cpu_rst_n   (cpu_rst_n),
    .cpu_en      (cpu_en),
    .cycle_count (cycle_count),
    .state       (state),
    .done        (done),
    .timeout     (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string tag;
    int    en;
    int    count;
    int    tmo;
    int    dn;
    int    st;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // After reset release (or entry to INIT), cpu_rst_n stays low until the n-th edge.
  task automatic check_hold(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      @(posedge clock);
      #1;
      check_eq({tag, ".rst_n"}, 32'(cpu_rst_n), (k == n) ? 32'd1 : 32'd0);
      check_eq({tag, ".state"}, 32'(state), (k == n) ? SIdle : SInit);
      check_eq({tag, ".en"}, 32'(cpu_en), 32'd0);
    end
  endtask

  task automatic restart(input string tag);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check_eq({tag, ".state"}, 32'(state), SInit);
    check_eq({tag, ".count"}, cycle_count, 32'd0);
    check_eq({tag, ".tmo"}, 32'(timeout), 32'd0);
    check_eq({tag, ".done"}, 32'(done), 32'd0);
    check_eq({tag, ".rst_n"}, 32'(cpu_rst_n), 32'd0);
    check_hold(tag, ResetHold);
  endtask

  // Issue a one-cycle command and act as the CPU until the enabled burst ends.
  task automatic run_cmd(input string tag, input logic c_start, input logic c_step,
                         input logic c_stop, input int halt_at, input int stop_at,
                         input int wait_cycles, input int exp_en, input int exp_count,
                         input int exp_tmo, input int exp_done, input int exp_state);
    exp_t e;
    int   en_cnt;
    e = '{tag, exp_en, exp_count, exp_tmo, exp_done, exp_state};
    sb.push_back(e);
    @(negedge clock);
    start  = c_start;
    step   = c_step;
    stop   = c_stop;
    en_cnt = 0;
    for (int i = 0; i < wait_cycles; i++) begin
      @(negedge clock);
      start = 1'b0;
      step  = 1'b0;
      if (cpu_en) en_cnt++;
      cpu_halt = cpu_en && (en_cnt == halt_at);
      stop     = cpu_en && (en_cnt == stop_at);
      if (en_cnt > 0 && !cpu_en) break;
    end
    cpu_halt = 1'b0;
    stop     = 1'b0;
    e = sb.pop_front();
    check_eq({e.tag, ".en_cycles"}, en_cnt, e.en);
    check_eq({e.tag, ".count"}, cycle_count, e.count);
    check_eq({e.tag, ".tmo"}, 32'(timeout), e.tmo);
    check_eq({e.tag, ".done"}, 32'(done), e.dn);
    check_eq({e.tag, ".state"}, 32'(state), e.st);
    check_eq({e.tag, ".cpu_en_after"}, 32'(cpu_en), 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    step     = 1'b0;
    stop     = 1'b0;
    cpu_halt = 1'b0;
    #1;
    check_eq("rst.rst_n", 32'(cpu_rst_n), 32'd0);
    check_eq("rst.en", 32'(cpu_en), 32'd0);
    check_eq("rst.count", cycle_count, 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    check_eq("rst.tmo", 32'(timeout), 32'd0);
    check_eq("rst.state", 32'(state), SInit);
    @(negedge clock);
    reset_n = 1'b1;
    check_hold("release", ResetHold);

    run_cmd("halt10", 1'b1, 1'b0, 1'b0, 10, 0, 100, 10, 10, 0, 1, SHalted);
    restart("restart1");
    run_cmd("budget", 1'b1, 1'b0, 1'b0, 0, 0, 100, 16, 16, 1, 1, SHalted);
    restart("restart2");

    for (int i = 1; i <= 3; i++) begin
      run_cmd($sformatf("step%0d", i), 1'b0, 1'b1, 1'b0, 0, 0, 10, 1, i, 0, 0, SIdle);
    end
    run_cmd("start_stop", 1'b1, 1'b0, 1'b1, 0, 0, 5, 0, 3, 0, 0, SIdle);
    run_cmd("stop_run", 1'b1, 1'b0, 1'b0, 0, 5, 100, 5, 8, 0, 0, SIdle);
    run_cmd("stop_halt", 1'b1, 1'b0, 1'b0, 5, 5, 100, 5, 13, 0, 1, SHalted);

    restart("restart3");
    run_cmd("halt_at_budget", 1'b1, 1'b0, 1'b0, 16, 0, 100, 16, 16, 0, 1, SHalted);
    restart("restart4");

    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("midrun.running", 32'(cpu_en), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midrun.rst_n", 32'(cpu_rst_n), 32'd0);
    check_eq("midrun.en", 32'(cpu_en), 32'd0);
    check_eq("midrun.count", cycle_count, 32'd0);
    check_eq("midrun.done", 32'(done), 32'd0);
    check_eq("midrun.tmo", 32'(timeout), 32'd0);
    check_eq("midrun.state", 32'(state), SInit);
    @(negedge clock);
    reset_n = 1'b1;
    check_hold("rerelease", ResetHold);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
